// File: rtl/regfile_scoreboard_4bit.sv
// regfile_scoreboard_4bit
// 8 x 4-bit register file with a per-register busy scoreboard.
// Source operands are read combinationally, with write-through bypass from
// the writeback port. Issue stalls on RAW or WAW hazards against registers
// that are still pending. R0 is hardwired to zero and is never marked busy.
module regfile_scoreboard_4bit #(
  parameter int DATA_W = 4,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_src_a,
  input  logic [AW-1:0]     iss_src_b,
  input  logic [AW-1:0]     iss_dst,
  output logic              iss_stall,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [NREG-1:0]   busy_vec
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   eff_busy;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   busy_nxt;
  logic              accept;

  // Operand read: R0 reads zero, a same-cycle writeback to the address wins
  // over storage so the issue stage never sees a stale value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [AW-1:0]     addr,
    input logic [DATA_W-1:0] stored,
    input logic              byp_vld,
    input logic [AW-1:0]     byp_addr,
    input logic [DATA_W-1:0] byp_data
  );
    if (addr == '0)
      return '0;
    else if (byp_vld && (byp_addr == addr))
      return byp_data;
    else
      return stored;
  endfunction

  // Hazard detection, issue acceptance and next scoreboard state.
  // A register retiring this cycle is not a hazard; a same-cycle set wins
  // over clear so a new producer issuing to it keeps the bit high.
  always_comb begin
    wb_hit      = wb_valid ? (NREG'(1) << wb_addr) : '0;
    eff_busy    = busy & ~wb_hit;
    iss_stall   = rst_n && iss_valid &&
                  (eff_busy[iss_src_a] || eff_busy[iss_src_b] || eff_busy[iss_dst]);
    accept      = iss_valid && !iss_stall;
    set_vec     = accept ? (NREG'(1) << iss_dst) : '0;
    set_vec[0]  = 1'b0;
    busy_nxt    = set_vec | (busy & ~wb_hit);
    busy_nxt[0] = 1'b0;
  end

  // Read ports are forced to zero while reset is held so a writeback arriving
  // during reset cannot leak through the bypass.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rst_n) begin
      rd_data_a = read_port(iss_src_a, regs[iss_src_a], wb_valid, wb_addr, wb_data);
      rd_data_b = read_port(iss_src_b, regs[iss_src_b], wb_valid, wb_addr, wb_data);
    end
  end

  // Register storage: writeback updates any register except R0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_valid && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard bits: reset discards every pending producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_scoreboard_4bit.sv
// Testbench for regfile_scoreboard_4bit: directed hazard scenarios followed by
// randomized traffic, with expectations queued by the driver and compared by
// an independent monitor on the falling clock edge.
module tb_regfile_scoreboard_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iss_valid = 1'b0;
  logic [2:0] iss_src_a = '0;
  logic [2:0] iss_src_b = '0;
  logic [2:0] iss_dst = '0;
  logic       iss_stall;
  logic [3:0] rd_data_a;
  logic [3:0] rd_data_b;
  logic       wb_valid = 1'b0;
  logic [2:0] wb_addr = '0;
  logic [3:0] wb_data = '0;
  logic [7:0] busy_vec;

  regfile_scoreboard_4bit #(.DATA_W(4), .NREG(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
    .iss_dst(iss_dst), .iss_stall(iss_stall),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] busy;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  // Reference model: register contents and pending flags as plain arrays.
  logic [3:0] m_reg  [8];
  bit         m_busy [8];

  function automatic void model_clear();
    for (int r = 0; r < 8; r++) begin
      m_reg[r]  = 4'h0;
      m_busy[r] = 1'b0;
    end
  endfunction

  // A register is a hazard if pending and not being retired right now.
  function automatic bit hazard(input logic [2:0] r);
    if (r == 3'd0) return 1'b0;
    if (wb_valid && wb_addr == r) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic logic [3:0] operand(input logic [2:0] r);
    if (r == 3'd0) return 4'h0;
    if (wb_valid && wb_addr == r) return wb_data;
    return m_reg[r];
  endfunction

  function automatic bit model_stall();
    return iss_valid && (hazard(iss_src_a) || hazard(iss_src_b) || hazard(iss_dst));
  endfunction

  function automatic void push_expect(input string name);
    exp_t e;
    e.name = name;
    if (!rst_n) begin
      e.stall = 1'b0; e.a = 4'h0; e.b = 4'h0; e.busy = 8'h00;
    end else begin
      e.stall = model_stall();
      e.a     = operand(iss_src_a);
      e.b     = operand(iss_src_b);
      for (int r = 0; r < 8; r++) e.busy[r] = m_busy[r];
    end
    q.push_back(e);
  endfunction

  // State after the coming clock edge, from the current inputs.
  function automatic void model_advance();
    bit acc;
    acc = iss_valid && !model_stall();
    if (wb_valid && wb_addr != 3'd0) m_reg[wb_addr] = wb_data;
    if (wb_valid) m_busy[wb_addr] = 1'b0;
    if (acc && iss_dst != 3'd0) m_busy[iss_dst] = 1'b1;
  endfunction

  task automatic step(input string name, input logic iv, input logic [2:0] sa,
                      input logic [2:0] sb, input logic [2:0] dst, input logic wv,
                      input logic [2:0] wa, input logic [3:0] wd);
    @(posedge clk); #1;
    iss_valid = iv; iss_src_a = sa; iss_src_b = sb; iss_dst = dst;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    push_expect(name);
    if (rst_n) model_advance();
  endtask

  // Reset pulse wholly between two rising edges; checked while still low.
  task automatic reset_pulse(input string name, input logic [2:0] sa);
    @(posedge clk); #1;
    iss_valid = 1'b1; iss_src_a = sa; iss_src_b = sa; iss_dst = 3'd0;
    wb_valid = 1'b1; wb_addr = sa; wb_data = 4'h5;
    rst_n = 1'b0;
    model_clear();
    push_expect(name);
    #6;
    iss_valid = 1'b0; wb_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, "stall", {7'd0, iss_stall}, {7'd0, e.stall});
        check(e.name, "rd_a",  {4'd0, rd_data_a}, {4'd0, e.a});
        check(e.name, "rd_b",  {4'd0, rd_data_b}, {4'd0, e.b});
        check(e.name, "busy",  busy_vec, e.busy);
      end
    end
  end

  initial begin
    model_clear();
    // Held in reset with live inputs: everything reads zero.
    step("in_reset", 1'b1, 3'd5, 3'd5, 3'd5, 1'b1, 3'd5, 4'h9);
    @(posedge clk); #1;
    iss_valid = 1'b0; wb_valid = 1'b0;
    rst_n = 1'b1;

    // Write R3, then asynchronous reset clears it.
    step("wb_r3_bypass", 1'b0, 3'd3, 3'd0, 3'd0, 1'b1, 3'd3, 4'hA);
    step("r3_stored",    1'b0, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);
    reset_pulse("async_reset", 3'd3);
    step("r3_after_rst", 1'b0, 3'd3, 3'd3, 3'd0, 1'b0, 3'd0, 4'h0);

    // R0 ignores writes.
    step("wb_r0",        1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 4'hF);
    step("r0_read",      1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);

    // Write then read through bypass and storage.
    step("wb_r5_bypass", 1'b0, 3'd0, 3'd5, 3'd0, 1'b1, 3'd5, 4'h9);
    step("r5_stored",    1'b0, 3'd0, 3'd5, 3'd0, 1'b0, 3'd0, 4'h0);

    // RAW stall and release.
    step("issue_dst2",   1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 3'd0, 4'h0);
    step("raw_stall0",   1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);
    step("raw_stall1",   1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);
    step("raw_stall2",   1'b1, 3'd2, 3'd5, 3'd0, 1'b0, 3'd0, 4'h0);
    step("raw_release",  1'b1, 3'd2, 3'd0, 3'd0, 1'b1, 3'd2, 4'h6);
    step("raw_cleared",  1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);

    // WAW stall.
    step("issue_dst4",   1'b1, 3'd0, 3'd0, 3'd4, 1'b0, 3'd0, 4'h0);
    step("waw_stall",    1'b1, 3'd0, 3'd0, 3'd4, 1'b0, 3'd0, 4'h0);
    step("waw_hold",     1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd4, 4'h1);
    step("waw_cleared",  1'b0, 3'd4, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);

    // Same-cycle set and clear on R6.
    step("issue_dst6",   1'b1, 3'd0, 3'd0, 3'd6, 1'b0, 3'd0, 4'h0);
    step("set_clr_r6",   1'b1, 3'd0, 3'd6, 3'd6, 1'b1, 3'd6, 4'h3);
    step("r6_still_bsy", 1'b0, 3'd6, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);
    step("r6_retire",    1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd6, 4'h7);

    // Idle with busy operands, then issue to R0.
    step("issue_dst1",   1'b1, 3'd0, 3'd0, 3'd1, 1'b0, 3'd0, 4'h0);
    step("idle_busy_op", 1'b0, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 4'h0);
    step("issue_dst0",   1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 4'h0);
    step("after_dst0",   1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 4'h2);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse("rand_reset", 3'($urandom_range(0, 7)));
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending, expected 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
